alu_exec: RTL and testbench
===========================

// Module: alu_exec
// PURPOSE
//  Execute stage directly downstream of the regfile. Accepts one decoded op per handshake.
//  Reads two operands through the regfile read ports and computes the result.
//  Writes results back through the regfile write ports; Z/N/C/V flags are held locally.
//  Single-cycle ops: ADD..INC. Iterative 16-cycle ops: MUL, DIV.
// PARAMETERS
//  DATA_W   16  operand/result width (only 16 supported)
//  SEL_W    4   regfile select width (0000 = zero on read, no write on write)
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       synchronous reset, active-high
//  op_valid      in   1       decoded op present
//  op_ready      out  1       stage can accept (state IDLE)
//  op_code       in   4       operation (see BEHAVIOUR)
//  op_src1/2     in   SEL_W   operand register selects
//  op_dst1/2     in   SEL_W   result selects (dst2 used only by MUL hi / DIV remainder)
//  rf_out1_sel   out  SEL_W   to regfile out1_sel; rf_out1_data in DATA_W from regfile
//  rf_out2_sel   out  SEL_W   to regfile out2_sel; rf_out2_data in DATA_W from regfile
//  rf_in1_sel    out  SEL_W   to regfile in1_sel; rf_in1_data out DATA_W
//  rf_in2_sel    out  SEL_W   to regfile in2_sel; rf_in2_data out DATA_W
//  flags         out  4       {Z,N,C,V}, registered
//  done          out  1       1-cycle pulse in WB
// BEHAVIOUR
//  Reset: state IDLE; op_ready=1; all rf_*_sel=0; rf_in*_data=0; flags=0; done=0.
//  Reset mid-op aborts the op: no writeback, flags cleared.
//  FSM states:
//   IDLE  -> READ  on op_valid&op_ready; latch op fields.
//   READ  -> drive rf_out1_sel=src1 and rf_out2_sel=src2; register both operands (regfile read is combinational).
//            Single-cycle op: register result/flags, then go to WB. MUL/DIV: go to ITER.
//   ITER  -> 16 iterations, 1 bit per cycle, then go to WB.
//   WB    -> drive rf_in1_sel=dst1/data and rf_in2_sel=dst2/data for exactly 1 cycle; update flags; done=1; go to IDLE.
//  Outside WB all rf_in*_sel are 0 (no write). Outside READ all rf_out*_sel are 0.
//  Latency, accept edge at T:
//   single-cycle op: WB at T+2, op_ready at T+3.
//   MUL/DIV: WB at T+18.
//  op_ready is low from T+1 until IDLE is re-entered; no back-to-back accept.
//  Ops (x=src1, y=src2, both 16b; byte-reg sources arrive zero-extended):
//   0 ADD x+y      1 SUB x-y     2 AND    3 OR     4 XOR    5 NOT x   6 SHL x<<y[3:0]
//   7 SHR logical  8 SAR arith   9 MOV x  10 CMP (x-y, flags only; dst sels forced 0)
//   11 MUL unsigned 16x16: dst1=lo, dst2=hi    12 DIV unsigned: dst1=quot, dst2=rem
//   13 INC x+1     14 DEC x-1    15 reserved: no write, flags unchanged, done still pulses
//  For ops other than MUL/DIV, rf_in2_sel=0 in WB.
//  Flags:
//   Z = dst1 result==0; N = result[15].
//   C = carry out (ADD/INC), borrow (SUB/CMP/DEC), last bit shifted out (shifts; 0 when shift count is 0),
//       hi!=0 (MUL); 0 otherwise.
//   V = signed overflow (ADD/SUB/CMP/INC/DEC), divide-by-zero (DIV); 0 otherwise.
//  DIV by 0: quot=16'hFFFF, rem=x, V=1; still takes the full 16 ITER cycles.
//  dst1==dst2 in WB: the regfile gives in2 priority, so the MUL hi / DIV rem value lands. This is intended.
//  Byte-register destinations (1100..1111): full 16b data is driven; the regfile truncates.
// STRUCTURE
//  Shared package hlcpu_pkg holds:
//   opcode localparams OP_ADD..OP_DIV;
//   register select codes (SEL_NONE=0, SEL_A=1 .. SEL_SP=7, SEL_HX=12 .. SEL_LY=15);
//   FSM state encoding; flag bit indices.
//  One sub-module: alu_muldiv_seq. Contains the shift-add multiplier and restoring divider
//   (start/busy/done, 5-bit iteration counter, 32b accumulator).
//  The combinational single-cycle ALU stays inline.
// TESTING
//  - Reset then idle: rf_in1_sel=rf_in2_sel=0 every cycle, op_ready=1, flags=0.
//  - ADD a=16'h7FFF, b=1, dst1=A, accepted at T: rf_in1_sel=1, data=16'h8000 at T+2;
//    flags N=1, V=1, Z=0, C=0; op_ready rises at T+3.
//  - CMP c=5, d=5: no write in WB (both sels 0), Z=1, C=0; then SHL 16'h8001 by 1 -> 16'h0002, C=1.
//  - MUL 16'h1234 x 16'h0100, dst1=B, dst2=C: WB at T+18 with B=16'h3400, C=16'h0012, C flag=1.
//  - DIV 100/7, dst1=A, dst2=D -> A=14, D=2. DIV 9/0 -> quot 16'hFFFF, rem 9, V=1.
//  - rst asserted at ITER cycle 8 of a MUL: no WB, state IDLE next cycle, flags 0;
//    next op proceeds normally.

Source files
------------

// File: rtl/hlcpu_pkg.sv
// Shared definitions for the hlcpu execute stage: opcodes, register selects,
// FSM state encoding and flag bit positions.
package hlcpu_pkg;

  localparam int HL_DATA_W = 16;
  localparam int HL_SEL_W  = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_SAR = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam logic [3:0] OP_DIV = 4'd12;
  localparam logic [3:0] OP_INC = 4'd13;
  localparam logic [3:0] OP_DEC = 4'd14;
  localparam logic [3:0] OP_RSV = 4'd15;

  localparam logic [3:0] SEL_NONE = 4'd0;
  localparam logic [3:0] SEL_A    = 4'd1;
  localparam logic [3:0] SEL_B    = 4'd2;
  localparam logic [3:0] SEL_C    = 4'd3;
  localparam logic [3:0] SEL_D    = 4'd4;
  localparam logic [3:0] SEL_E    = 4'd5;
  localparam logic [3:0] SEL_F    = 4'd6;
  localparam logic [3:0] SEL_SP   = 4'd7;
  localparam logic [3:0] SEL_HX   = 4'd12;
  localparam logic [3:0] SEL_LX   = 4'd13;
  localparam logic [3:0] SEL_HY   = 4'd14;
  localparam logic [3:0] SEL_LY   = 4'd15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_ITER = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 3;

  function automatic logic is_multicycle(input logic [3:0] code);
    return (code == OP_MUL) || (code == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative 16x16 unsigned shift-add multiplier and restoring divider,
// one result bit per cycle over 16 cycles.
module alu_muldiv_seq
  import hlcpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_div,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic        busy,
  output logic        done,
  output logic [15:0] res_lo,
  output logic [15:0] res_hi
);

  logic [31:0] acc_r;
  logic [15:0] opb_r;
  logic        div_r;
  logic [4:0]  cnt_r;
  logic [16:0] mul_sum_s;
  logic [16:0] rem_s;
  logic [15:0] rem_diff_s;
  logic [31:0] acc_next_s;

  // Divide: acc holds {partial remainder, dividend bits / quotient bits}.
  // A zero divisor always subtracts, giving quot=FFFF and rem=dividend.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[31:16]} + (acc_r[0] ? {1'b0, opb_r} : 17'd0);
    rem_s      = {acc_r[31:16], acc_r[15]};
    rem_diff_s = rem_s[15:0] - opb_r;
    if (div_r) begin
      if (rem_s >= {1'b0, opb_r}) begin
        acc_next_s = {rem_diff_s, acc_r[14:0], 1'b1};
      end else begin
        acc_next_s = {rem_s[15:0], acc_r[14:0], 1'b0};
      end
    end else begin
      acc_next_s = {mul_sum_s, acc_r[15:1]};
    end
  end

  // Iteration counter and accumulator; done pulses after the 16th step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= 32'd0;
      opb_r <= 16'd0;
      div_r <= 1'b0;
      cnt_r <= 5'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc_r <= {16'd0, opa};
        opb_r <= opb;
        div_r <= is_div;
        cnt_r <= 5'd16;
        busy  <= 1'b1;
      end else if (busy) begin
        acc_r <= acc_next_s;
        cnt_r <= cnt_r - 5'd1;
        if (cnt_r == 5'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign res_lo = acc_r[15:0];
  assign res_hi = acc_r[31:16];

endmodule

// File: rtl/alu_exec.sv
// Execute stage: reads operands from the regfile, runs single-cycle ALU ops
// inline or MUL/DIV through alu_muldiv_seq, and writes results back.
module alu_exec
  import hlcpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic [SEL_W-1:0]  op_src1,
  input  logic [SEL_W-1:0]  op_src2,
  input  logic [SEL_W-1:0]  op_dst1,
  input  logic [SEL_W-1:0]  op_dst2,
  output logic [SEL_W-1:0]  rf_out1_sel,
  input  logic [DATA_W-1:0] rf_out1_data,
  output logic [SEL_W-1:0]  rf_out2_sel,
  input  logic [DATA_W-1:0] rf_out2_data,
  output logic [SEL_W-1:0]  rf_in1_sel,
  output logic [DATA_W-1:0] rf_in1_data,
  output logic [SEL_W-1:0]  rf_in2_sel,
  output logic [DATA_W-1:0] rf_in2_data,
  output logic [3:0]        flags,
  output logic              done
);

  logic [1:0]  state_r;
  logic        phase_r;
  logic [3:0]  code_r;
  logic [3:0]  dst1_r;
  logic [3:0]  dst2_r;
  logic [15:0] a_r;
  logic [15:0] b_r;

  logic [15:0] b_eff_s;
  logic [16:0] sum_s;
  logic [16:0] diff_s;
  logic [16:0] shl_s;
  logic [16:0] shr_s;
  logic [16:0] sar_s;
  logic [15:0] alu_res_s;
  logic        alu_c_s;
  logic        alu_v_s;

  logic        mds_start_s;
  logic        mds_busy_s;
  logic        mds_done_s;
  logic [15:0] mds_lo_s;
  logic [15:0] mds_hi_s;

  // Single-cycle ALU on the latched operands; shifts keep one extra bit for C.
  always_comb begin
    b_eff_s   = ((code_r == OP_INC) || (code_r == OP_DEC)) ? 16'd1 : b_r;
    sum_s     = {1'b0, a_r} + {1'b0, b_eff_s};
    diff_s    = {1'b0, a_r} - {1'b0, b_eff_s};
    shl_s     = {1'b0, a_r} << b_r[3:0];
    shr_s     = {a_r, 1'b0} >> b_r[3:0];
    sar_s     = $signed({a_r, 1'b0}) >>> b_r[3:0];
    alu_res_s = 16'd0;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (code_r)
      OP_ADD, OP_INC: begin
        alu_res_s = sum_s[15:0];
        alu_c_s   = sum_s[16];
        alu_v_s   = (a_r[15] == b_eff_s[15]) && (sum_s[15] != a_r[15]);
      end
      OP_SUB, OP_CMP, OP_DEC: begin
        alu_res_s = diff_s[15:0];
        alu_c_s   = diff_s[16];
        alu_v_s   = (a_r[15] != b_eff_s[15]) && (diff_s[15] != a_r[15]);
      end
      OP_AND: alu_res_s = a_r & b_r;
      OP_OR:  alu_res_s = a_r | b_r;
      OP_XOR: alu_res_s = a_r ^ b_r;
      OP_NOT: alu_res_s = ~a_r;
      OP_MOV: alu_res_s = a_r;
      OP_SHL: begin
        alu_res_s = shl_s[15:0];
        alu_c_s   = shl_s[16];
      end
      OP_SHR: begin
        alu_res_s = shr_s[16:1];
        alu_c_s   = shr_s[0];
      end
      OP_SAR: begin
        alu_res_s = sar_s[16:1];
        alu_c_s   = sar_s[0];
      end
      default: begin
        alu_res_s = 16'd0;
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
      end
    endcase
  end

  // Sequencer loads straight from the regfile read data in the first READ cycle.
  assign mds_start_s = (state_r == ST_READ) && !phase_r && is_multicycle(code_r);

  alu_muldiv_seq u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (mds_start_s),
    .is_div (code_r == OP_DIV),
    .opa    (rf_out1_data),
    .opb    (rf_out2_data),
    .busy   (mds_busy_s),
    .done   (mds_done_s),
    .res_lo (mds_lo_s),
    .res_hi (mds_hi_s)
  );

  // Control FSM; every output is registered and cleared outside its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      phase_r     <= 1'b0;
      code_r      <= OP_ADD;
      dst1_r      <= SEL_NONE;
      dst2_r      <= SEL_NONE;
      a_r         <= 16'd0;
      b_r         <= 16'd0;
      op_ready    <= 1'b1;
      rf_out1_sel <= SEL_NONE;
      rf_out2_sel <= SEL_NONE;
      rf_in1_sel  <= SEL_NONE;
      rf_in2_sel  <= SEL_NONE;
      rf_in1_data <= 16'd0;
      rf_in2_data <= 16'd0;
      flags       <= 4'd0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (op_valid) begin
            code_r      <= op_code;
            dst1_r      <= op_dst1;
            dst2_r      <= op_dst2;
            rf_out1_sel <= op_src1;
            rf_out2_sel <= op_src2;
            op_ready    <= 1'b0;
            phase_r     <= 1'b0;
            state_r     <= ST_READ;
          end
        end
        ST_READ: begin
          if (!phase_r) begin
            a_r         <= rf_out1_data;
            b_r         <= rf_out2_data;
            rf_out1_sel <= SEL_NONE;
            rf_out2_sel <= SEL_NONE;
            if (is_multicycle(code_r)) begin
              state_r <= ST_ITER;
            end else begin
              phase_r <= 1'b1;
            end
          end else begin
            phase_r     <= 1'b0;
            state_r     <= ST_WB;
            done        <= 1'b1;
            rf_in1_data <= alu_res_s;
            rf_in2_data <= 16'd0;
            rf_in2_sel  <= SEL_NONE;
            if (code_r == OP_RSV) begin
              rf_in1_sel <= SEL_NONE;
            end else begin
              rf_in1_sel    <= (code_r == OP_CMP) ? SEL_NONE : dst1_r;
              flags[FLAG_Z] <= (alu_res_s == 16'd0);
              flags[FLAG_N] <= alu_res_s[15];
              flags[FLAG_C] <= alu_c_s;
              flags[FLAG_V] <= alu_v_s;
            end
          end
        end
        ST_ITER: begin
          if (mds_done_s) begin
            state_r       <= ST_WB;
            done          <= 1'b1;
            rf_in1_sel    <= dst1_r;
            rf_in2_sel    <= dst2_r;
            rf_in1_data   <= mds_lo_s;
            rf_in2_data   <= mds_hi_s;
            flags[FLAG_Z] <= (mds_lo_s == 16'd0);
            flags[FLAG_N] <= mds_lo_s[15];
            flags[FLAG_C] <= (code_r == OP_MUL) && (mds_hi_s != 16'd0);
            flags[FLAG_V] <= (code_r == OP_DIV) && (b_r == 16'd0);
          end else if (!mds_busy_s) begin
            state_r  <= ST_IDLE;
            op_ready <= 1'b1;
          end
        end
        ST_WB: begin
          rf_in1_sel  <= SEL_NONE;
          rf_in2_sel  <= SEL_NONE;
          rf_in1_data <= 16'd0;
          rf_in2_data <= 16'd0;
          op_ready    <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          rf_in1_sel  <= SEL_NONE;
          rf_in2_sel  <= SEL_NONE;
          rf_out1_sel <= SEL_NONE;
          rf_out2_sel <= SEL_NONE;
          op_ready    <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases plus random ops against
// an arithmetic reference model, with a simple read-only regfile model.
module tb_alu_exec;
  import hlcpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_code, op_src1, op_src2, op_dst1, op_dst2;
  logic [3:0]  rf_out1_sel, rf_out2_sel, rf_in1_sel, rf_in2_sel;
  logic [15:0] rf_out1_data, rf_out2_data, rf_in1_data, rf_in2_data;
  logic [3:0]  flags;
  logic        done;

  logic [15:0] regs [16];
  logic [3:0]  flags_exp;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  assign rf_out1_data = regs[rf_out1_sel];
  assign rf_out2_data = regs[rf_out2_sel];

  alu_exec #(.DATA_W(16), .SEL_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_code      (op_code),
    .op_src1      (op_src1),
    .op_src2      (op_src2),
    .op_dst1      (op_dst1),
    .op_dst2      (op_dst2),
    .rf_out1_sel  (rf_out1_sel),
    .rf_out1_data (rf_out1_data),
    .rf_out2_sel  (rf_out2_sel),
    .rf_out2_data (rf_out2_data),
    .rf_in1_sel   (rf_in1_sel),
    .rf_in1_data  (rf_in1_data),
    .rf_in2_sel   (rf_in2_sel),
    .rf_in2_data  (rf_in2_data),
    .flags        (flags),
    .done         (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model written from the op definitions with integer arithmetic.
  task automatic model(input logic [3:0] code, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] r1, output logic [15:0] r2,
                       output logic [3:0] fl, output logic upd);
    int sx, sb, sr, t, s, bu;
    longint p;
    logic c, v;
    sx  = $signed(x);
    bu  = ((code == OP_INC) || (code == OP_DEC)) ? 1 : int'(y);
    sb  = ((code == OP_INC) || (code == OP_DEC)) ? 1 : int'($signed(y));
    s   = int'(y[3:0]);
    r1  = 16'd0;
    r2  = 16'd0;
    c   = 1'b0;
    v   = 1'b0;
    upd = 1'b1;
    case (code)
      OP_ADD, OP_INC: begin
        t  = int'(x) + bu;
        r1 = t[15:0];
        c  = (t > 65535);
        sr = sx + sb;
        v  = (sr > 32767) || (sr < -32768);
      end
      OP_SUB, OP_CMP, OP_DEC: begin
        t  = int'(x) - bu;
        r1 = t[15:0];
        c  = (int'(x) < bu);
        sr = sx - sb;
        v  = (sr > 32767) || (sr < -32768);
      end
      OP_AND: r1 = x & y;
      OP_OR:  r1 = x | y;
      OP_XOR: r1 = x ^ y;
      OP_NOT: r1 = ~x;
      OP_MOV: r1 = x;
      OP_SHL: begin
        t  = int'(x) << s;
        r1 = t[15:0];
        c  = (s != 0) && t[16];
      end
      OP_SHR: begin
        r1 = x >> s;
        c  = (s != 0) && x[s-1];
      end
      OP_SAR: begin
        sr = sx >>> s;
        r1 = sr[15:0];
        c  = (s != 0) && x[s-1];
      end
      OP_MUL: begin
        p  = longint'(x) * longint'(y);
        r1 = p[15:0];
        r2 = p[31:16];
        c  = (r2 != 16'd0);
      end
      OP_DIV: begin
        if (y == 16'd0) begin
          r1 = 16'hFFFF;
          r2 = x;
          v  = 1'b1;
        end else begin
          r1 = x / y;
          r2 = x % y;
        end
      end
      default: upd = 1'b0;
    endcase
    fl = {(r1 == 16'd0), r1[15], c, v};
  endtask

  task automatic run_op(input logic [3:0] code, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [3:0] d1, input logic [3:0] d2,
                        input logic [15:0] x, input logic [15:0] y);
    logic [15:0] xv, yv, e1, e2;
    logic [3:0]  fl, es1, es2;
    logic        upd;
    int          lat, k;
    if (s1 != 4'd0) regs[s1] = (s1 >= 4'd12) ? {8'd0, x[7:0]} : x;
    if (s2 != 4'd0) regs[s2] = (s2 >= 4'd12) ? {8'd0, y[7:0]} : y;
    xv = regs[s1];
    yv = regs[s2];
    model(code, xv, yv, e1, e2, fl, upd);
    es1 = ((code == OP_CMP) || (code == OP_RSV)) ? 4'd0 : d1;
    es2 = ((code == OP_MUL) || (code == OP_DIV)) ? d2 : 4'd0;
    lat = ((code == OP_MUL) || (code == OP_DIV)) ? 18 : 2;
    @(negedge clk);
    check("ready_idle", {31'd0, op_ready}, 32'd1);
    op_valid = 1'b1;
    op_code  = code;
    op_src1  = s1;
    op_src2  = s2;
    op_dst1  = d1;
    op_dst2  = d2;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    k = 0;
    while ((done !== 1'b1) && (k < 40)) begin
      check("ready_low", {31'd0, op_ready}, 32'd0);
      check("no_write", {24'd0, rf_in1_sel, rf_in2_sel}, 32'd0);
      if (k == 0) check("read_sel", {24'd0, rf_out1_sel, rf_out2_sel}, {24'd0, s1, s2});
      if (k >= 2) check("out_sel_idle", {24'd0, rf_out1_sel, rf_out2_sel}, 32'd0);
      @(negedge clk);
      k++;
    end
    check("latency", k, lat);
    check("wb_sel1", {28'd0, rf_in1_sel}, {28'd0, es1});
    check("wb_sel2", {28'd0, rf_in2_sel}, {28'd0, es2});
    if (es1 != 4'd0) check("wb_data1", {16'd0, rf_in1_data}, {16'd0, e1});
    if (es2 != 4'd0) check("wb_data2", {16'd0, rf_in2_data}, {16'd0, e2});
    if (upd) flags_exp = fl;
    check("flags", {28'd0, flags}, {28'd0, flags_exp});
    @(negedge clk);
    check("ready_back", {31'd0, op_ready}, 32'd1);
    check("sels_after", {24'd0, rf_in1_sel, rf_in2_sel}, 32'd0);
    check("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [3:0]  rc, rs1, rs2, rd1, rd2;
    logic [15:0] rx, ry;
    for (int i = 0; i < 16; i++) regs[i] = 16'd0;
    rst = 1'b1; op_valid = 1'b0; op_code = 4'd0;
    op_src1 = 4'd0; op_src2 = 4'd0; op_dst1 = 4'd0; op_dst2 = 4'd0;
    flags_exp = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_ready", {31'd0, op_ready}, 32'd1);
      check("rst_sels", {16'd0, rf_in1_sel, rf_in2_sel, rf_out1_sel, rf_out2_sel}, 32'd0);
      check("rst_flags", {28'd0, flags}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
    end

    run_op(OP_ADD, SEL_B, SEL_C, SEL_A, SEL_NONE, 16'h7FFF, 16'h0001);
    check("add_flags", {28'd0, flags}, 32'h5);
    run_op(OP_CMP, SEL_C, SEL_D, SEL_A, SEL_NONE, 16'd5, 16'd5);
    check("cmp_flags", {28'd0, flags}, 32'h8);
    run_op(OP_SHL, SEL_B, SEL_C, SEL_A, SEL_NONE, 16'h8001, 16'd1);
    check("shl_flags", {28'd0, flags}, 32'h2);
    run_op(OP_MUL, SEL_D, SEL_E, SEL_B, SEL_C, 16'h1234, 16'h0100);
    check("mul_flags", {28'd0, flags}, 32'h2);
    run_op(OP_DIV, SEL_B, SEL_C, SEL_A, SEL_D, 16'd100, 16'd7);
    check("div_flags", {28'd0, flags}, 32'h0);
    run_op(OP_DIV, SEL_B, SEL_NONE, SEL_A, SEL_D, 16'd9, 16'd0);
    check("div0_flags", {28'd0, flags}, 32'h5);
    run_op(OP_RSV, SEL_B, SEL_C, SEL_A, SEL_D, 16'd0, 16'd0);
    run_op(OP_MUL, SEL_A, SEL_B, SEL_C, SEL_C, 16'hFFFF, 16'hFFFF);

    // Reset in the middle of a MUL must abort without any writeback.
    regs[SEL_B] = 16'h00FF;
    regs[SEL_C] = 16'h0101;
    @(negedge clk);
    op_valid = 1'b1; op_code = OP_MUL; op_src1 = SEL_B; op_src2 = SEL_C;
    op_dst1 = SEL_A; op_dst2 = SEL_D;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    flags_exp = 4'd0;
    check("abort_ready", {31'd0, op_ready}, 32'd1);
    check("abort_flags", {28'd0, flags}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      check("abort_nowb", {27'd0, done, rf_in1_sel, rf_in2_sel}, 32'd0);
      @(negedge clk);
    end
    run_op(OP_MUL, SEL_B, SEL_C, SEL_A, SEL_D, 16'h00FF, 16'h0101);

    for (int i = 0; i < 40; i++) begin
      rc  = 4'($urandom_range(0, 15));
      rs1 = 4'($urandom_range(0, 15));
      rs2 = 4'($urandom_range(0, 15));
      rd1 = 4'($urandom_range(0, 15));
      rd2 = 4'($urandom_range(0, 15));
      rx  = 16'($urandom);
      ry  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      run_op(rc, rs1, rs2, rd1, rd2, rx, ry);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
